// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (bit 0 = segment a),
// decoded digit codes, and the readback FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK = 4'hE;
    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_STABLE = 2'd1,
        ST_DECODE      = 2'd2,
        ST_DONE        = 2'd3
    } state_e;

    // Forward mapping used by the encoder; codes above 9 other than BLANK go dark too.
    function automatic logic [6:0] bcd2seg(input logic [3:0] digit);
        case (digit)
            4'd0:    bcd2seg = SEG_0;
            4'd1:    bcd2seg = SEG_1;
            4'd2:    bcd2seg = SEG_2;
            4'd3:    bcd2seg = SEG_3;
            4'd4:    bcd2seg = SEG_4;
            4'd5:    bcd2seg = SEG_5;
            4'd6:    bcd2seg = SEG_6;
            4'd7:    bcd2seg = SEG_7;
            4'd8:    bcd2seg = SEG_8;
            4'd9:    bcd2seg = SEG_9;
            default: bcd2seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pat2bcd.sv
// Combinational inverse of the segment encoder: one active-low pattern to a digit
// code plus an illegal-pattern flag.
module seg7_pat2bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] bcd_c_o,
    output logic       bad_c_o
);

    always_comb begin
        bcd_c_o = BCD_BAD;
        bad_c_o = 1'b1;
        case (pat_i)
            SEG_0:     begin bcd_c_o = 4'd0;      bad_c_o = 1'b0; end
            SEG_1:     begin bcd_c_o = 4'd1;      bad_c_o = 1'b0; end
            SEG_2:     begin bcd_c_o = 4'd2;      bad_c_o = 1'b0; end
            SEG_3:     begin bcd_c_o = 4'd3;      bad_c_o = 1'b0; end
            SEG_4:     begin bcd_c_o = 4'd4;      bad_c_o = 1'b0; end
            SEG_5:     begin bcd_c_o = 4'd5;      bad_c_o = 1'b0; end
            SEG_6:     begin bcd_c_o = 4'd6;      bad_c_o = 1'b0; end
            SEG_7:     begin bcd_c_o = 4'd7;      bad_c_o = 1'b0; end
            SEG_8:     begin bcd_c_o = 4'd8;      bad_c_o = 1'b0; end
            SEG_9:     begin bcd_c_o = 4'd9;      bad_c_o = 1'b0; end
            SEG_BLANK: begin bcd_c_o = BCD_BLANK; bad_c_o = 1'b0; end
            default:   begin bcd_c_o = BCD_BAD;   bad_c_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// Snapshots the active-low 7-segment buses, waits for them to settle, then decodes
// one digit per cycle and publishes the result atomically with a one-cycle strobe.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7*NUM_DIGITS-1:0]   hex_in,
    input  logic                      sample_en,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     bad_mask,
    output logic                      timeout,
    output logic                      snap_valid,
    output logic                      busy
);

    localparam int unsigned HEX_W  = 7 * NUM_DIGITS;
    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SCNT_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q,    state_d;
    logic [HEX_W-1:0]   shadow_q,   shadow_d;
    logic [SCNT_W-1:0]  scnt_q,     scnt_d;
    logic [TCNT_W-1:0]  tcnt_q,     tcnt_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [BCD_W-1:0]   work_bcd_q, work_bcd_d;
    logic [NUM_DIGITS-1:0] work_bad_q, work_bad_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic [NUM_DIGITS-1:0] bad_q,   bad_d;
    logic               timeout_q,  timeout_d;
    logic               snap_q,     snap_d;
    logic               busy_q,     busy_d;

    logic [6:0]         cur_pat;
    logic [3:0]         dec_bcd;
    logic               dec_bad;

    // Digit currently being decoded, taken from the frozen shadow copy.
    always_comb begin
        cur_pat = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_pat = shadow_q[7*i +: 7];
        end
    end

    seg7_pat2bcd u_pat2bcd (
        .pat_i   (cur_pat),
        .bcd_c_o (dec_bcd),
        .bad_c_o (dec_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            scnt_q     <= '0;
            tcnt_q     <= '0;
            idx_q      <= '0;
            work_bcd_q <= '0;
            work_bad_q <= '0;
            bcd_q      <= {NUM_DIGITS{BCD_BLANK}};
            bad_q      <= '0;
            timeout_q  <= 1'b0;
            snap_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            scnt_q     <= scnt_d;
            tcnt_q     <= tcnt_d;
            idx_q      <= idx_d;
            work_bcd_q <= work_bcd_d;
            work_bad_q <= work_bad_d;
            bcd_q      <= bcd_d;
            bad_q      <= bad_d;
            timeout_q  <= timeout_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        scnt_d     = scnt_q;
        tcnt_d     = tcnt_q;
        idx_d      = idx_q;
        work_bcd_d = work_bcd_q;
        work_bad_d = work_bad_q;
        bcd_d      = bcd_q;
        bad_d      = bad_q;
        timeout_d  = timeout_q;
        snap_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample_en) begin
                    shadow_d = hex_in;
                    scnt_d   = '0;
                    tcnt_d   = '0;
                    state_d  = ST_WAIT_STABLE;
                end
            end

            // Stability wins over timeout; timeout fires once the full budget has elapsed.
            ST_WAIT_STABLE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (hex_in == shadow_q) begin
                    scnt_d = scnt_q + 1'b1;
                end else begin
                    shadow_d = hex_in;
                    scnt_d   = '0;
                end
                if (scnt_d == SCNT_W'(STABLE_CYC)) begin
                    idx_d   = '0;
                    state_d = ST_DECODE;
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC)) begin
                    work_bcd_d = {NUM_DIGITS{BCD_BAD}};
                    work_bad_d = '1;
                    bcd_d      = {NUM_DIGITS{BCD_BAD}};
                    bad_d      = '1;
                    timeout_d  = 1'b1;
                    snap_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end

            ST_DECODE: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        work_bcd_d[4*i +: 4] = dec_bcd;
                        work_bad_d[i]        = dec_bad;
                    end
                end
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    bcd_d     = work_bcd_d;
                    bad_d     = work_bad_d;
                    timeout_d = 1'b0;
                    snap_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bcd_out    = bcd_q;
    assign bad_mask   = bad_q;
    assign timeout    = timeout_q;
    assign snap_valid = snap_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: table vectors, randomized snapshots against
// a lookup-based reference, and hand-written timing/reset sequences.
module tb_seg7_readback;

    localparam int unsigned N  = 6;
    localparam int unsigned SC = 4;
    localparam int unsigned TC = 64;
    localparam int LAT = SC + N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7*N-1:0] hex_in;
    logic          sample_en;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]  bad_mask;
    logic          timeout;
    logic          snap_valid;
    logic          busy;

    always #5 clk = ~clk;

    seg7_readback #(.NUM_DIGITS(N), .STABLE_CYC(SC), .TIMEOUT_CYC(TC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hex_in     (hex_in),
        .sample_en  (sample_en),
        .bcd_out    (bcd_out),
        .bad_mask   (bad_mask),
        .timeout    (timeout),
        .snap_valid (snap_valid),
        .busy       (busy)
    );

    typedef struct {
        logic [7*N-1:0] hex;
        logic [4*N-1:0] bcd;
        logic [N-1:0]   bad;
    } vec_t;

    logic [6:0]     seg_tbl [10];
    vec_t           tbl [5];
    int             n_vec = 0;
    int             n_err = 0;
    logic [4*N-1:0] prev_bcd = {N{4'hE}};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: search the legal-pattern list, blank is special, anything else is bad.
    function automatic void model(input logic [7*N-1:0] hex,
                                  output logic [4*N-1:0] bcd, output logic [N-1:0] bad);
        logic [6:0] p;
        for (int d = 0; d < int'(N); d++) begin
            p = hex[7*d +: 7];
            bcd[4*d +: 4] = 4'hF;
            bad[d] = 1'b1;
            if (p == 7'h7F) begin
                bcd[4*d +: 4] = 4'hE;
                bad[d] = 1'b0;
            end
            for (int v = 0; v < 10; v++) begin
                if (p == seg_tbl[v]) begin
                    bcd[4*d +: 4] = 4'(v);
                    bad[d] = 1'b0;
                end
            end
        end
    endfunction

    // mode 0: static; 1: toggle digit0 every 2 cycles; 2: switch to alt after 1st WAIT edge;
    // 3: switch to alt once decoding has started.
    task automatic snap(input logic [7*N-1:0] hex, input int mode,
                        input logic [7*N-1:0] alt, output int lat);
        hex_in = hex;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        lat = 0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        while (!snap_valid && lat < 200) begin
            if (lat == 5) chk("hold_prev_bcd", 64'(bcd_out), 64'(prev_bcd));
            if (mode == 1 && (lat % 2) == 1)
                hex_in[6:0] = (hex_in[6:0] == hex[6:0]) ? alt[6:0] : hex[6:0];
            if (mode == 2 && lat == 1) hex_in = alt;
            if (mode == 3 && lat == 4) hex_in = alt;
            tick();
            lat++;
        end
        chk("snap_seen", 64'(snap_valid), 64'd1);
    endtask

    task automatic finish_snap(input string name, input int lat, input int exp_lat,
                               input logic [4*N-1:0] eb, input logic [N-1:0] ebad, input logic eto);
        chk($sformatf("%s_latency", name), 64'(lat), 64'(exp_lat));
        chk($sformatf("%s_bcd", name), 64'(bcd_out), 64'(eb));
        chk($sformatf("%s_bad", name), 64'(bad_mask), 64'(ebad));
        chk($sformatf("%s_timeout", name), 64'(timeout), 64'(eto));
        prev_bcd = eb;
        tick();
        chk($sformatf("%s_pulse_end", name), 64'(snap_valid), 64'd0);
        chk($sformatf("%s_idle", name), 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7*N-1:0] h, alt;
        logic [4*N-1:0] eb;
        logic [N-1:0]   ebad;
        int             lat;

        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        tbl[0] = '{{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 24'h123456, 6'b000000};
        tbl[1] = '{{7'h40, 7'h40, 7'h55, 7'h7F, 7'h40, 7'h40}, 24'h00FE00, 6'b001000};
        tbl[2] = '{{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}, 24'h888888, 6'b000000};
        tbl[3] = '{{7'h10, 7'h00, 7'h78, 7'h40, 7'h79, 7'h7F}, 24'h98701E, 6'b000000};
        tbl[4] = '{{7'h41, 7'h12, 7'h12, 7'h12, 7'h12, 7'h7E}, 24'hF5555F, 6'b100001};

        rst_n = 1'b0;
        sample_en = 1'b0;
        hex_in = '0;
        repeat (3) tick();
        chk("rst_bcd", 64'(bcd_out), 64'(24'hEEEEEE));
        chk("rst_bad", 64'(bad_mask), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_snap", 64'(snap_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            snap(tbl[i].hex, 0, tbl[i].hex, lat);
            finish_snap($sformatf("tbl%0d", i), lat, LAT, tbl[i].bcd, tbl[i].bad, 1'b0);
        end

        // Digit0 never settles: full timeout budget elapses, then one more edge to DONE.
        alt = tbl[0].hex;
        alt[6:0] = 7'h40;
        snap(tbl[0].hex, 1, alt, lat);
        finish_snap("timeout", lat, TC + 1, {N{4'hF}}, {N{1'b1}}, 1'b1);

        // Single glitch on the second WAIT cycle restarts the stability count.
        model(tbl[3].hex, eb, ebad);
        snap(tbl[0].hex, 2, tbl[3].hex, lat);
        finish_snap("glitch", lat, LAT + 2, eb, ebad, 1'b0);

        // Input changes after stability is reached must not reach the result.
        model(tbl[0].hex, eb, ebad);
        snap(tbl[0].hex, 3, tbl[4].hex, lat);
        finish_snap("frozen", lat, LAT, eb, ebad, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int d = 0; d < int'(N); d++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                if (sel < 7)       h[7*d +: 7] = seg_tbl[$urandom_range(0, 9)];
                else if (sel == 7) h[7*d +: 7] = 7'h7F;
                else               h[7*d +: 7] = 7'($urandom);
            end
            model(h, eb, ebad);
            snap(h, 0, h, lat);
            finish_snap($sformatf("rand%0d", r), lat, LAT, eb, ebad, 1'b0);
        end

        // Continuous request: accept, LAT edges to DONE, one edge in DONE, one IDLE edge.
        hex_in = tbl[2].hex;
        sample_en = 1'b1;
        tick();
        for (int c = 0; c <= 40; c++) begin
            logic es, eby;
            es  = (c >= LAT) && ((c - LAT) % (LAT + 2) == 0);
            eby = !((c >= LAT + 1) && ((c - LAT - 1) % (LAT + 2) == 0));
            chk($sformatf("cont_snap_c%0d", c), 64'(snap_valid), 64'(es));
            chk($sformatf("cont_busy_c%0d", c), 64'(busy), 64'(eby));
            tick();
        end
        sample_en = 1'b0;
        repeat (20) tick();
        chk("cont_drained", 64'(busy), 64'd0);
        chk("cont_bcd", 64'(bcd_out), 64'(tbl[2].bcd));

        // Reset while decoding: outputs drop immediately and the snapshot never completes.
        hex_in = tbl[0].hex;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd", 64'(bcd_out), 64'(24'hEEEEEE));
        chk("midrst_bad", 64'(bad_mask), 64'd0);
        chk("midrst_timeout", 64'(timeout), 64'd0);
        chk("midrst_snap", 64'(snap_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            chk($sformatf("midrst_nosnap%0d", c), 64'(snap_valid), 64'd0);
        end
        prev_bcd = {N{4'hE}};
        snap(tbl[0].hex, 0, tbl[0].hex, lat);
        finish_snap("after_rst", lat, LAT, tbl[0].bcd, tbl[0].bad, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
